// File: rtl/tag_sort_pkg.sv
// Shared widths and FSM encoding for the tag-sorting datapath.
// Tag issue control, flow register file and storage all import this.
package tag_sort_pkg;

  localparam int T_W = 6;  // tag value width
  localparam int S_W = 6;  // SPB address width
  localparam int I_W = 6;  // packet ID width
  localparam int F_W = 3;  // flow ID width
  localparam int L_W = 6;  // normalized length width

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CALC  = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

endpackage

// File: rtl/tag_flow_regfile.sv
// Per-flow last-finish-tag storage: one write port, one combinational read port.
// Contents are qualified by valid bits held by the owner, so no reset is needed.
module tag_flow_regfile #(
  parameter int F = 3,
  parameter int T = 6
) (
  input  logic         clk,
  input  logic         we,
  input  logic [F-1:0] waddr,
  input  logic [T-1:0] wdata,
  input  logic [F-1:0] raddr,
  output logic [T-1:0] rdata
);

  logic [T-1:0] mem [2**F];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tag_issue_ctrl.sv
// Computes a WFQ-style finish tag per arriving packet and issues one insert
// request to the tag storage, waiting (with timeout) for its completion.
module tag_issue_ctrl
  import tag_sort_pkg::*;
#(
  parameter int T   = T_W,
  parameter int S   = S_W,
  parameter int I   = I_W,
  parameter int F   = F_W,
  parameter int L   = L_W,
  parameter int TMO = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pck_valid,
  output logic         pck_ready,
  input  logic [F-1:0] pck_flow,
  input  logic [L-1:0] pck_len,
  input  logic [I-1:0] pck_id,
  input  logic [S-1:0] pck_spb_addr,
  output logic         ena,
  output logic [T-1:0] matching_tag,
  output logic [T-1:0] incoming_tag,
  output logic [I-1:0] o_pck_id,
  output logic [S-1:0] o_pck_spb_addr,
  input  logic         wr_done,
  input  logic         srv_valid,
  input  logic [T-1:0] srv_tag,
  output logic         err_tmo
);

  localparam int CW = (TMO < 2) ? 1 : $clog2(TMO + 1);

  logic [1:0]      state;
  logic [F-1:0]    flow_r;
  logic [L-1:0]    len_r;
  logic [T-1:0]    vtime;
  logic [2**F-1:0] flow_vld;
  logic [CW-1:0]   cnt;

  logic [T-1:0]    last_rd;
  logic            rf_we;
  logic            last_ok;
  logic [T-1:0]    base_c;
  logic [T-1:0]    match_c;
  logic [T:0]      sum_c;
  logic [T-1:0]    inc_c;

  tag_flow_regfile #(.F(F), .T(T)) u_rf (
    .clk  (clk),
    .we   (rf_we),
    .waddr(flow_r),
    .wdata(incoming_tag),
    .raddr(flow_r),
    .rdata(last_rd)
  );

  // Only a completion seen while waiting commits the tag; stray pulses are dropped.
  assign rf_we     = (state == ST_WAIT) && wr_done;
  assign pck_ready = (state == ST_IDLE) && !rst;

  // Finish tag: one extra bit catches overflow so the result saturates instead of wrapping.
  always_comb begin
    last_ok = flow_vld[flow_r];
    match_c = last_ok ? last_rd : vtime;
    base_c  = (last_ok && (last_rd > vtime)) ? last_rd : vtime;
    sum_c   = {1'b0, base_c} + (T+1)'(len_r);
    inc_c   = sum_c[T] ? {T{1'b1}} : sum_c[T-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      flow_r         <= '0;
      len_r          <= '0;
      vtime          <= '0;
      flow_vld       <= '0;
      cnt            <= '0;
      ena            <= 1'b0;
      err_tmo        <= 1'b0;
      matching_tag   <= '0;
      incoming_tag   <= '0;
      o_pck_id       <= '0;
      o_pck_spb_addr <= '0;
    end else begin
      ena <= 1'b0;
      // Virtual time only moves forward; CALC in this cycle still sees the old value.
      if (srv_valid && (srv_tag > vtime)) vtime <= srv_tag;

      case (state)
        ST_IDLE: begin
          if (pck_valid) begin
            flow_r         <= pck_flow;
            len_r          <= pck_len;
            o_pck_id       <= pck_id;
            o_pck_spb_addr <= pck_spb_addr;
            state          <= ST_CALC;
          end
        end
        ST_CALC: begin
          incoming_tag <= inc_c;
          matching_tag <= match_c;
          ena          <= 1'b1;
          cnt          <= '0;
          state        <= ST_ISSUE;
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        default: begin
          if (wr_done) begin
            flow_vld[flow_r] <= 1'b1;
            state            <= ST_IDLE;
          end else if (cnt == CW'(TMO - 1)) begin
            err_tmo <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tag_issue_ctrl.sv
// Table-driven bench for tag_issue_ctrl with an expected-insert scoreboard.
module tb_tag_issue_ctrl;

  localparam int T = 6, S = 6, I = 6, F = 3, L = 6, TMO = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         pck_valid;
  logic         pck_ready;
  logic [F-1:0] pck_flow;
  logic [L-1:0] pck_len;
  logic [I-1:0] pck_id;
  logic [S-1:0] pck_spb_addr;
  logic         ena;
  logic [T-1:0] matching_tag;
  logic [T-1:0] incoming_tag;
  logic [I-1:0] o_pck_id;
  logic [S-1:0] o_pck_spb_addr;
  logic         wr_done;
  logic         srv_valid;
  logic [T-1:0] srv_tag;
  logic         err_tmo;

  always #5 clk = ~clk;

  tag_issue_ctrl #(.T(T), .S(S), .I(I), .F(F), .L(L), .TMO(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .pck_valid     (pck_valid),
    .pck_ready     (pck_ready),
    .pck_flow      (pck_flow),
    .pck_len       (pck_len),
    .pck_id        (pck_id),
    .pck_spb_addr  (pck_spb_addr),
    .ena           (ena),
    .matching_tag  (matching_tag),
    .incoming_tag  (incoming_tag),
    .o_pck_id      (o_pck_id),
    .o_pck_spb_addr(o_pck_spb_addr),
    .wr_done       (wr_done),
    .srv_valid     (srv_valid),
    .srv_tag       (srv_tag),
    .err_tmo       (err_tmo)
  );

  // mode: 0 = complete with wr_done, 1 = let it time out, 2 = reset while waiting
  typedef struct {
    int flow; int len; int pre_srv; int pre_wr; int srv_calc; int mode;
    int exp_inc; int exp_match;
  } vec_t;

  typedef struct { int inc; int match; int id; int addr; } exp_t;

  vec_t vecs[12];
  exp_t sb[$];
  int   errs   = 0;
  int   checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    exp_t e;
    exp_t g;
    int   lat;
    if (v.pre_srv != 0) begin
      srv_valid = 1'b1; srv_tag = T'(v.pre_srv);
      tick();
      srv_valid = 1'b0;
    end
    if (v.pre_wr != 0) begin
      wr_done = 1'b1;
      tick();
      wr_done = 1'b0;
    end
    chk($sformatf("ready_idle[%0d]", idx), int'(pck_ready), 1);
    pck_valid    = 1'b1;
    pck_flow     = F'(v.flow);
    pck_len      = L'(v.len);
    pck_id       = I'(idx + 1);
    pck_spb_addr = S'(40 + idx);
    e = '{v.exp_inc, v.exp_match, idx + 1, 40 + idx};
    sb.push_back(e);
    tick();
    pck_valid = 1'b0;
    if (v.srv_calc != 0) begin
      srv_valid = 1'b1; srv_tag = T'(v.srv_calc);
    end
    lat = 1;
    while (!ena && lat < 8) begin
      tick();
      srv_valid = 1'b0;
      lat++;
    end
    srv_valid = 1'b0;
    chk($sformatf("ena_latency[%0d]", idx), lat, 2);
    g = sb.pop_front();
    chk($sformatf("incoming_tag[%0d]", idx), int'(incoming_tag), g.inc);
    chk($sformatf("matching_tag[%0d]", idx), int'(matching_tag), g.match);
    chk($sformatf("o_pck_id[%0d]", idx), int'(o_pck_id), g.id);
    chk($sformatf("o_pck_spb_addr[%0d]", idx), int'(o_pck_spb_addr), g.addr);
    case (v.mode)
      0: begin
        tick();
        chk($sformatf("ena_one_cycle[%0d]", idx), int'(ena), 0);
        chk($sformatf("tag_stable[%0d]", idx), int'(incoming_tag), g.inc);
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        chk($sformatf("ready_after_wr[%0d]", idx), int'(pck_ready), 1);
      end
      1: begin
        repeat (TMO) tick();
        chk("tmo_not_early_ready", int'(pck_ready), 0);
        chk("tmo_not_early_err", int'(err_tmo), 0);
        chk("tmo_hold_tag", int'(incoming_tag), g.inc);
        tick();
        chk("tmo_ready", int'(pck_ready), 1);
        chk("tmo_err", int'(err_tmo), 1);
      end
      default: begin
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rst_ena", int'(ena), 0);
        chk("rst_ready", int'(pck_ready), 0);
        chk("rst_incoming", int'(incoming_tag), 0);
        chk("rst_matching", int'(matching_tag), 0);
        chk("rst_id", int'(o_pck_id), 0);
        chk("rst_addr", int'(o_pck_spb_addr), 0);
        chk("rst_err", int'(err_tmo), 0);
        rst = 1'b0;
        tick();
        chk("rst_ready_after", int'(pck_ready), 1);
      end
    endcase
  endtask

  initial begin
    //          flow len pre_srv pre_wr srv_calc mode inc match
    vecs[0]  = '{0,  3,  0,  0, 0,  0,  3,  0};
    vecs[1]  = '{0,  2,  0,  0, 0,  0,  5,  3};
    vecs[2]  = '{1,  4, 10,  0, 0,  0, 14, 10};
    vecs[3]  = '{2, 50,  0,  0, 0,  0, 60, 10};
    vecs[4]  = '{2, 10,  0,  0, 0,  0, 63, 60};
    vecs[5]  = '{3,  1,  0,  0, 0,  1, 11, 10};
    vecs[6]  = '{3,  2,  0,  1, 0,  0, 12, 10};
    vecs[7]  = '{0,  1,  0,  0, 0,  2, 11,  5};
    vecs[8]  = '{0,  3,  0,  0, 0,  0,  3,  0};
    vecs[9]  = '{1,  2,  0,  0, 20, 0,  2,  0};
    vecs[10] = '{5,  1,  0,  0, 0,  0, 21, 20};
    vecs[11] = '{6,  1,  5,  0, 0,  0, 21, 20};

    rst = 1'b1; pck_valid = 1'b0; pck_flow = '0; pck_len = '0; pck_id = '0;
    pck_spb_addr = '0; wr_done = 1'b0; srv_valid = 1'b0; srv_tag = '0;
    tick();
    tick();
    chk("ready_in_reset", int'(pck_ready), 0);
    rst = 1'b0;
    tick();
    chk("reset_ena", int'(ena), 0);
    chk("reset_err", int'(err_tmo), 0);
    chk("reset_incoming", int'(incoming_tag), 0);
    chk("reset_matching", int'(matching_tag), 0);
    chk("reset_ready", int'(pck_ready), 1);

    for (int i = 0; i < 12; i++) begin
      run(vecs[i], i);
      if (i == 6) chk("err_sticky", int'(err_tmo), 1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
